struct_design_blk: RTL and testbench



---
 rtl/struct_design_pkg.sv | 24 ++
 rtl/struct_calc.sv | 11 +
 rtl/struct_design_blk.sv | 38 +++
 tb/tb_struct_design_blk.sv | 107 ++++++++++
 4 files changed

// File: rtl/struct_design_pkg.sv
// Shared types and the add/compare function for the struct-typed arithmetic leaf.
package struct_design_pkg;

    localparam int unsigned DATA_W = 16;

    typedef struct packed {
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } operand_pair_t;

    typedef struct packed {
        logic [DATA_W:0] sum;
        logic            eq;
    } result_t;

    // Zero-extend both operands so the carry lands in the sum MSB
    function automatic result_t calc(input operand_pair_t ops);
        result_t res;
        res.sum = (DATA_W+1)'(ops.a) + (DATA_W+1)'(ops.b);
        res.eq  = (ops.a == ops.b);
        return res;
    endfunction

endpackage

// File: rtl/struct_calc.sv
// Combinational map from an operand pair to its sum/equality result.
module struct_calc
    import struct_design_pkg::*;
(
    input  operand_pair_t ops,
    output result_t       res
);

    assign res = calc(ops);

endmodule

// File: rtl/struct_design_blk.sv
// Registered 16-bit add-and-compare unit; one result register drives both outputs.
module struct_design_blk
    import struct_design_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [DATA_W-1:0] inp_A,
    input  logic [DATA_W-1:0] inp_B,
    output logic [DATA_W:0]   data_C,
    output logic              is_eq
);

    operand_pair_t ops;
    result_t       next_res;
    result_t       res_q;

    assign ops.a = inp_A;
    assign ops.b = inp_B;

    struct_calc u_calc (
        .ops (ops),
        .res (next_res)
    );

    // Reset wins over enable; hold when disabled so idle inputs cannot disturb outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            res_q <= '0;
        end else if (enable) begin
            res_q <= next_res;
        end
    end

    assign data_C = res_q.sum;
    assign is_eq  = res_q.eq;

endmodule

// File: tb/tb_struct_design_blk.sv
// Self-checking bench: directed cases then randomized traffic against an arithmetic reference.
module tb_struct_design_blk;

    logic        clk;
    logic        rst;
    logic        enable;
    logic [15:0] inp_A;
    logic [15:0] inp_B;
    logic [16:0] data_C;
    logic        is_eq;

    int unsigned n_pass;
    int unsigned n_total;

    // Reference state: what the outputs should show after the most recent edge
    int unsigned ref_sum;
    bit          ref_eq;

    struct_design_blk dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .inp_A  (inp_A),
        .inp_B  (inp_B),
        .data_C (data_C),
        .is_eq  (is_eq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of stimulus, advance the reference, then compare just after the edge
    task automatic step(input string tag, input bit r, input bit en,
                        input logic [15:0] a, input logic [15:0] b);
        rst    = r;
        enable = en;
        inp_A  = a;
        inp_B  = b;
        @(posedge clk);
        #1;
        if (r) begin
            ref_sum = 0;
            ref_eq  = 1'b0;
        end else if (en) begin
            ref_sum = int'(a) + int'(b);
            ref_eq  = (a == b);
        end
        check({tag, ".sum"}, 32'(data_C), ref_sum);
        check({tag, ".eq"},  32'(is_eq),  32'(ref_eq));
    endtask

    initial begin
        logic [15:0] ra;
        logic [15:0] rb;
        bit          rr;
        bit          re;
        n_pass  = 0;
        n_total = 0;
        ref_sum = 0;
        ref_eq  = 1'b0;
        rst     = 1'b1;
        enable  = 1'b0;
        inp_A   = '0;
        inp_B   = '0;

        step("reset0", 1'b1, 1'b0, 16'h0000, 16'h0000);
        step("reset1", 1'b1, 1'b1, 16'h1234, 16'h1234);
        step("idle_after_reset", 1'b0, 1'b0, 16'h5555, 16'h5555);

        step("zero_zero", 1'b0, 1'b1, 16'h0000, 16'h0000);
        step("one_two",   1'b0, 1'b1, 16'h0001, 16'h0002);
        step("c_c",       1'b0, 1'b1, 16'h000C, 16'h000C);
        step("max_max",   1'b0, 1'b1, 16'hFFFF, 16'hFFFF);
        check("max_max.literal", 32'(data_C), 32'h0001_FFFE);
        step("hold",      1'b0, 1'b0, 16'h0001, 16'h0000);
        step("hold_x",    1'b0, 1'b0, 'x, 'x);
        step("max_plus_one", 1'b0, 1'b1, 16'hFFFF, 16'h0001);
        step("rst_over_en",  1'b1, 1'b1, 16'h8000, 16'h8000);
        step("fresh_after_rst", 1'b0, 1'b1, 16'h8000, 16'h8000);

        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            case ($urandom_range(0, 5))
                0:       rb = ra;
                1:       rb = 16'hFFFF;
                2:       rb = 16'h0000;
                default: rb = 16'($urandom);
            endcase
            rr = ($urandom_range(0, 49) == 0);
            re = ($urandom_range(0, 3) != 0);
            step("random", rr, re, ra, rb);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
